// File: rtl/cmp_seq_pkg.sv
// Shared types and constants for the serial magnitude-compare sequencer.
// The optional early-exit mode is selected in cmp_seq_ctrl with CMP_SEQ_EARLY_EXIT_EN.
package cmp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_GT   = 2'd1;
    localparam logic [1:0] RES_EQ   = 2'd2;
    localparam logic [1:0] RES_LT   = 2'd3;

    function automatic int slices_of(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned compare; exactly one of gt/eq/lt is high.
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Serial WIDTH-bit unsigned compare, 2 bits per cycle, MSB pair first.
// Define CMP_SEQ_EARLY_EXIT_EN to finish on the first differing slice.
module cmp_seq_ctrl
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int SLICES = slices_of(WIDTH);
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    // Handshake: start is accepted only in IDLE or DONE; operands are sampled on
    // that edge, done pulses for one cycle, and gt/eq/lt hold until the next done.
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IDX_W-1:0] idx;
    logic [1:0]       dec;
    logic [1:0]       dec_nxt;
    logic [1:0]       res;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;
    logic             accept;
    logic             finish;

    cmp2_slice u_slice (
        .a  (sh_a[WIDTH-1 -: 2]),
        .b  (sh_b[WIDTH-1 -: 2]),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    // The first differing slice decides; later slices never override it.
    always_comb begin
        dec_nxt = dec;
        if (dec == RES_NONE) begin
            dec_nxt = s_eq ? RES_NONE : (s_gt ? RES_GT : (s_lt ? RES_LT : RES_NONE));
        end
    end

`ifdef CMP_SEQ_EARLY_EXIT_EN
    assign finish = (idx == '0) || (dec_nxt != RES_NONE);
`else
    assign finish = (idx == '0);
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            idx   <= '0;
            dec   <= RES_NONE;
            res   <= RES_NONE;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sh_a <= a;
                sh_b <= b;
                idx  <= IDX_W'(SLICES - 1);
                dec  <= RES_NONE;
            end else if (state == RUN) begin
                sh_a <= sh_a << 2;
                sh_b <= sh_b << 2;
                idx  <= idx - 1'b1;
                dec  <= dec_nxt;
                if (finish) begin
                    res <= (dec_nxt == RES_NONE) ? RES_EQ : dec_nxt;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign gt   = (res == RES_GT);
    assign eq   = (res == RES_EQ);
    assign lt   = (res == RES_LT);

endmodule
